// File: rtl/uart_pkg.sv
// Types and widths shared by the UART receive path.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    localparam int UART_ERR_CNT_W = 8;

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two byte FIFO using wrap-bit pointers; occupancy is the pointer difference.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int Depth = 16
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  uart_byte_t               wrData,
    output uart_byte_t               rdData,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(Depth):0]   count
);

    localparam int AW = $clog2(Depth);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : gBadDepth
        $error("byte_fifo: Depth must be a power of two and at least 2");
    end

    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    uart_byte_t  mem [Depth];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    always_ff @(posedge clk) begin
        if (!nReset || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PtrOne;
            if (pop)  rptr <= rptr + PtrOne;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wrData;
    end

    assign rdData = mem[rptr[AW-1:0]];
    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign count  = wptr - rptr;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: gated push, sticky overflow,
// saturating framing-error count and a synchronous flush.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int Depth = 16
) (
    input  logic                        clk,
    input  logic                        nReset,
    input  uart_byte_t                  rxData,
    input  logic                        rxDone,
    input  logic                        rxErr,
    output uart_byte_t                  outData,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [$clog2(Depth):0]      count,
    output logic                        overflow,
    output logic [UART_ERR_CNT_W-1:0]   errCount,
    input  logic                        clear
);

    localparam logic [UART_ERR_CNT_W-1:0] ErrMax = {UART_ERR_CNT_W{1'b1}};
    localparam logic [UART_ERR_CNT_W-1:0] ErrOne = {{(UART_ERR_CNT_W-1){1'b0}}, 1'b1};

    uart_byte_t headData;
    logic       empty;
    logic       full;
    logic       pop;
    logic       push;
    logic       drop;

    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign pop  = outValid && outReady;
    assign push = rxDone && (!full || pop);
    assign drop = rxDone && full && !pop;

    byte_fifo #(.Depth(Depth)) uFifo (
        .clk    (clk),
        .nReset (nReset),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .wrData (rxData),
        .rdData (headData),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

    assign outValid = !empty;
    assign outData  = outValid ? headData : '0;

    always_ff @(posedge clk) begin
        if (!nReset || clear) begin
            overflow <= 1'b0;
            errCount <= '0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (rxErr && errCount != ErrMax) errCount <= errCount + ErrOne;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int Depth = 16;

    logic             clk = 1'b0;
    logic             nReset;
    uart_byte_t       rxData;
    logic             rxDone;
    logic             rxErr;
    uart_byte_t       outData;
    logic             outValid;
    logic             outReady;
    logic [4:0]       count;
    logic             overflow;
    logic [7:0]       errCount;
    logic             clear;

    int nTests = 0;
    int nFails = 0;

    // reference model state
    byte unsigned mQ[$];
    bit           mOverflow;
    int           mErrCount;
    int           pushTotal;

    uart_rx_fifo #(.Depth(Depth)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .rxData   (rxData),
        .rxDone   (rxDone),
        .rxErr    (rxErr),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .count    (count),
        .overflow (overflow),
        .errCount (errCount),
        .clear    (clear)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic stepModel();
        bit mPop;
        mPop = (mQ.size() != 0) && outReady;
        if (!nReset || clear) begin
            mQ.delete();
            mOverflow = 0;
            mErrCount = 0;
        end else begin
            if (rxErr && mErrCount < 255) mErrCount++;
            if (mPop) void'(mQ.pop_front());
            if (rxDone) begin
                if (mQ.size() < Depth) begin
                    mQ.push_back(rxData);
                    pushTotal++;
                end else begin
                    mOverflow = 1;
                end
            end
        end
    endtask

    task automatic compareAll();
        checkVal("outValid", outValid, mQ.size() != 0);
        checkVal("outData",  outData,  (mQ.size() != 0) ? mQ[0] : 0);
        checkVal("count",    count,    mQ.size());
        checkVal("overflow", overflow, mOverflow);
        checkVal("errCount", errCount, mErrCount);
    endtask

    task automatic tick();
        stepModel();
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic drive(input bit done, input byte unsigned data, input bit err,
                         input bit ready, input bit clr);
        rxDone   = done;
        rxData   = data;
        rxErr    = err;
        outReady = ready;
        clear    = clr;
        tick();
    endtask

    task automatic idle();
        drive(0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        nReset = 1'b0;
        rxData = '0; rxDone = 0; rxErr = 0; outReady = 0; clear = 0;
        mOverflow = 0; mErrCount = 0; pushTotal = 0;

        // reset, with a strobe that must be ignored
        drive(1, 8'h77, 1, 0, 0);
        checkVal("rstCount", count, 0);
        checkVal("rstValid", outValid, 0);
        nReset = 1'b1;
        idle();

        // basic flow
        drive(1, 8'hA5, 0, 0, 0);
        checkVal("basicData", outData, 8'hA5);
        checkVal("basicCount", count, 1);
        drive(0, 8'h00, 0, 1, 0);
        checkVal("basicEmptyValid", outValid, 0);
        checkVal("basicEmptyData", outData, 0);

        // fill and overflow
        for (int i = 0; i < 16; i++) drive(1, i[7:0], 0, 0, 0);
        drive(1, 8'h10, 0, 0, 0);
        checkVal("fillCount", count, 16);
        checkVal("fillOverflow", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            checkVal("drainOrder", outData, i);
            drive(0, 8'h00, 0, 1, 0);
        end
        checkVal("overflowSticky", overflow, 1);
        drive(0, 8'h00, 0, 0, 1);
        checkVal("overflowCleared", overflow, 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) drive(1, 8'h80 + i[7:0], 0, 0, 0);
        drive(1, 8'h55, 0, 1, 0);
        checkVal("fullPushPopCount", count, 16);
        checkVal("fullPushPopOverflow", overflow, 0);
        for (int i = 0; i < 15; i++) drive(0, 8'h00, 0, 1, 0);
        checkVal("lastIs55", outData, 8'h55);
        drive(0, 8'h00, 0, 1, 0);

        // streaming wrap
        pushTotal = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1, 8'($urandom), 0, 1, 0);
            checkVal("streamCountLe1", count <= 1, 1);
        end
        checkVal("streamPushes", pushTotal >= 96, 1);
        drive(0, 8'h00, 0, 1, 0);

        // error counter saturation with coincident bytes
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 1), 8'($urandom), 1, 1, 0);
        checkVal("errSat", errCount, 255);
        drive(0, 8'h00, 0, 1, 0);
        drive(0, 8'h00, 0, 0, 1);
        checkVal("errCleared", errCount, 0);

        // reset mid-operation
        for (int i = 0; i < 5; i++) drive(1, 8'($urandom), 1, 0, 0);
        nReset = 1'b0;
        drive(1, 8'hEE, 1, 0, 0);
        nReset = 1'b1;
        checkVal("midRstCount", count, 0);
        checkVal("midRstErr", errCount, 0);
        idle();
        checkVal("midRstStillEmpty", outValid, 0);

        // clear mid-operation with a coincident byte
        for (int i = 0; i < 5; i++) drive(1, 8'($urandom), 0, 0, 0);
        drive(1, 8'hDD, 1, 1, 1);
        checkVal("midClrCount", count, 0);
        idle();
        checkVal("midClrStillEmpty", outValid, 0);

        // random soak
        for (int i = 0; i < 3000; i++) begin
            nReset = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 99) < 2);
        end
        nReset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte the receiver reports, holds up to `Depth` bytes, and presents them to the consumer over a valid/ready interface. It also keeps a sticky overflow flag and a saturating count of framing errors, so that software or a bus wrapper can drain received data at its own rate.

## Interface
- `Depth`, 16: FIFO capacity in bytes. Must be a power of two and ≥ 2; elaboration fails otherwise.
- `clk` in 1: sole clock, all state updates on its rising edge.
- `nReset` in 1: reset, synchronous, active-low.
- `rxData` in 8: received byte from the receiver. Meaningful only while `rxDone` is high.
- `rxDone` in 1: one-cycle strobe marking that `rxData` holds a complete byte.
- `rxErr` in 1: one-cycle strobe marking a framing or sync error from the receiver.
- `outData` out 8: head byte. Equals 0 whenever `outValid` is low.
- `outValid` out 1: FIFO is non-empty.
- `outReady` in 1: consumer accepts the head byte this cycle.
- `count` out $clog2(Depth)+1: current occupancy, 0..Depth.
- `overflow` out 1: sticky flag, set when a byte is dropped because the FIFO is full.
- `errCount` out 8: number of `rxErr` strobes seen, saturating at 255.
- `clear` in 1: synchronous flush of contents and status.

## Operation
- Storage is a `Depth`×8 array.
- Pointers `wptr` and `rptr` are each $clog2(Depth)+1 bits; the MSB is the wrap bit.
  - `count = wptr - rptr`, computed modulo 2^(AW+1).
  - Empty when `wptr == rptr`.
  - Full when the low bits are equal and the MSBs differ.
- Pop: `pop = outValid && outReady`. `rptr` increments by 1.
- Push: `push = rxDone && (!full || pop)`. The array is written at `wptr[AW-1:0]` and `wptr` increments by 1.
- Full with simultaneous pop and `rxDone`: both succeed, the FIFO stays full, and `overflow` is not set.
- Drop: `rxDone && full && !pop`. The byte is discarded, `overflow` is set to 1, and the pointers are unchanged.
- Empty with `rxDone` and `outReady` in the same cycle: no pop, because `outValid` is low. The byte is pushed.
- `rxErr`: `errCount` increments, holding at 255. `rxErr` together with `rxDone` in the same cycle: the byte is still pushed and `errCount` still increments.
- `clear` has priority over all activity except reset:
  - `wptr`, `rptr`, `overflow` and `errCount` go to 0.
  - Any push, pop or `rxErr` in that cycle is ignored.
- `overflow` and `errCount` change only through drop, `rxErr`, `clear` or reset.
- Array contents are not reset; the `outData` gating keeps stale array contents off the output.

## Timing
- Reset (`nReset` low at a rising edge) sets:
  - `wptr = rptr = 0`
  - `outValid = 0`, `outData = 0`, `count = 0`
  - `overflow = 0`, `errCount = 0`
- Reset mid-stream discards all stored bytes. A strobe in the reset cycle is ignored.
- Push latency is 1 cycle: for `rxDone` sampled at edge N, the byte is at the head and `outValid = 1` after edge N, if the FIFO was empty.
- Pop takes effect at the edge where `outValid && outReady`. The next byte, or 0 with `outValid = 0`, appears after that edge.
- `outData` and `outValid` are combinational from registered state only. There is no combinational path from `outReady` or `rxDone` to any output.
- Throughput: one push and one pop per cycle, sustained.
- `count` reflects the state after the last edge.
- Wrap-around: pointers roll over from 2^(AW+1)-1 to 0 with no gap or duplicate.

## Structure
- Shared package `uart_pkg`:
  - `uart_byte_t` (logic [7:0]).
  - `UART_ERR_CNT_W = 8`.
- Sub-module `byte_fifo` holds the storage, the pointers and the full/empty/count logic, and is parameterised by `Depth`.
- `uart_rx_fifo` wraps `byte_fifo` and adds the `rxDone` push gating, overflow detection, the error counter and `clear`.

## Test plan
- Basic flow: push 0xA5 with `outReady = 0`. The next cycle shows `outValid = 1`, `outData = 0xA5`, `count = 1`. Assert `outReady` for one cycle; afterwards `outValid = 0`, `outData = 0`, `count = 0`.
- Fill and overflow (`Depth = 16`): push bytes 0x00..0x0F, then 0x10 while `outReady = 0`.
  - `count = 16` and `overflow = 1`.
  - Draining yields exactly 0x00..0x0F in order.
  - `overflow` stays 1 until `clear`.
- Full with simultaneous push and pop: FIFO full, `rxDone` with 0x55 and `outReady = 1` in the same cycle.
  - `count` stays 16 and `overflow` stays 0.
  - 0x55 is drained last.
- Streaming wrap: 100 bytes at one push per cycle with `outReady` held high. Output order matches input, `count ≤ 1` throughout, and the pointers wrap at least 3 times.
- Error counter: 300 `rxErr` strobes, some coincident with `rxDone`.
  - `errCount = 255`.
  - The coincident bytes are all delivered.
  - `clear` returns `errCount` to 0.
- Reset and clear mid-operation:
  - With 5 bytes stored, assert `nReset = 0` for one cycle. All outputs go to reset values and a strobe in that cycle is not stored.
  - Repeat with `clear` in place of reset, plus `rxDone` in the same cycle: `count = 0` and the byte is not stored.
